// File: rtl/wbuf_pkg.sv
// Shared types and constants for the uncached posted write buffer.
package wbuf_pkg;

   typedef enum logic [2:0] {IDLE, W_REQ, W_WAIT, R_REQ, R_WAIT} state_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // FIFO entry layout is {addr, size, wdata}
   function automatic int entry_width(input int addr_w, input int data_w);
      return addr_w + 2 + data_w;
   endfunction

   localparam int ENTRY_W = entry_width(ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/wbuf_fifo.sv
// Synchronous FIFO holding posted stores; head entry is visible without a pop.
module wbuf_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 66
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem[head];

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + PW'(1);
         if (do_pop)  head <= head + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; count and pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= din;
   end

endmodule

// File: rtl/uncached_wbuf.sv
// Posted write buffer for uncached accesses: stores acked at once and drained in
// order; loads wait for all older stores. state | meaning:
//   IDLE   | nothing in flight downstream
//   W_REQ  | head store presented, waiting for mem_addr_ok
//   W_WAIT | head store accepted, waiting for mem_data_ok
//   R_REQ  | latched load presented, waiting for mem_addr_ok
//   R_WAIT | load accepted, waiting for mem_data_ok
module uncached_wbuf
   import wbuf_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_addr_ok,
   output logic              cpu_data_ok,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   output logic              wbuf_empty
);
   localparam int EW = entry_width(ADDR_W, DATA_W);
   localparam int CW = $clog2(DEPTH) + 1;

   state_t            state, state_nxt;
   logic              rd_pend;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0]        rd_size;
   logic [CW-1:0]     count;
   logic              full, empty;
   logic [EW-1:0]     head;
   logic              st_ok, ld_ok, st_acc, ld_acc, pop, rd_done;

   // A load only issues from IDLE, where no pop can occur, and a load and a
   // store never arrive in the same cycle, so the load check needs no more.
   assign st_ok       = ~full & ~rd_pend;
   assign ld_ok       = empty & (state == IDLE) & ~rd_pend;
   assign cpu_addr_ok = cpu_wr ? st_ok : ld_ok;
   assign st_acc      = cpu_req & cpu_wr & st_ok;
   assign ld_acc      = cpu_req & ~cpu_wr & ld_ok;
   assign pop         = (state == W_WAIT) & mem_data_ok;
   assign rd_done     = (state == R_WAIT) & mem_data_ok;
   assign wbuf_empty  = empty & (state == IDLE) & ~rd_pend;

   wbuf_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (st_acc),
      .pop   (pop),
      .din   ({cpu_addr, cpu_size, cpu_wdata}),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_comb begin
      state_nxt = state;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = rd_addr;
      mem_size  = rd_size;
      mem_wdata = head[DATA_W-1:0];
      case (state)
         IDLE: begin
            if (!empty || st_acc)     state_nxt = W_REQ;
            else if (rd_pend || ld_acc) state_nxt = R_REQ;
         end
         W_REQ: begin
            mem_req  = 1'b1;
            mem_wr   = 1'b1;
            mem_addr = head[EW-1 -: ADDR_W];
            mem_size = head[DATA_W +: 2];
            if (mem_addr_ok) state_nxt = W_WAIT;
         end
         W_WAIT: begin
            mem_wr   = 1'b1;
            mem_addr = head[EW-1 -: ADDR_W];
            mem_size = head[DATA_W +: 2];
            if (mem_data_ok) state_nxt = (count > CW'(1) || st_acc) ? W_REQ : IDLE;
         end
         R_REQ: begin
            mem_req = 1'b1;
            if (mem_addr_ok) state_nxt = R_WAIT;
         end
         R_WAIT: begin
            if (mem_data_ok) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         rd_pend     <= 1'b0;
         rd_addr     <= '0;
         rd_size     <= '0;
         cpu_data_ok <= 1'b0;
         cpu_rdata   <= '0;
      end else begin
         state       <= state_nxt;
         cpu_data_ok <= st_acc | rd_done;
         if (ld_acc) begin
            rd_pend <= 1'b1;
            rd_addr <= cpu_addr;
            rd_size <= cpu_size;
         end
         if (rd_done) begin
            rd_pend   <= 1'b0;
            cpu_rdata <= mem_rdata;
         end
      end
   end

   a_no_ok_overlap: assert property (@(posedge clk) disable iff (rst)
      !(mem_addr_ok && mem_data_ok));

endmodule
